// File: rtl/apb_slave_mem.sv
// APB4 completer backed by a word memory; transfer takes 2 + cfg_wait_states cycles (setup, waits, completion).
// Backpressure via pready: wait count is latched at setup, pslverr flags range/alignment/security errors.
module apb_slave_mem #(
    parameter int                         ADDRESS_WIDTH = 32,
    parameter int                         DATA_WIDTH    = 32,
    parameter int                         MEM_SIZE_KB   = 12,
    parameter logic [ADDRESS_WIDTH-1:0]   BASE_ADDR     = '0,
    parameter int                         WAIT_WIDTH    = 4
) (
    input  logic                          pclk,
    input  logic                          preset_n,
    input  logic                          psel,
    input  logic                          penable,
    input  logic                          pwrite,
    input  logic [ADDRESS_WIDTH-1:0]      paddr,
    input  logic [DATA_WIDTH-1:0]         pwdata,
    input  logic [DATA_WIDTH/8-1:0]       pstrb,
    input  logic [2:0]                    pprot,
    output logic                          pready,
    output logic [DATA_WIDTH-1:0]         prdata,
    output logic                          pslverr,
    input  logic [WAIT_WIDTH-1:0]         cfg_wait_states,
    input  logic                          cfg_secure_only,
    output logic [15:0]                   err_count
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int DEPTH = MEM_SIZE_KB * 1024 / BYTES;
    localparam int LSB   = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int SPAN  = MEM_SIZE_KB * 1024;
    localparam logic [ADDRESS_WIDTH:0] END_ADDR = {1'b0, BASE_ADDR} + (ADDRESS_WIDTH+1)'(SPAN);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                  state_q, state_d;
    logic [WAIT_WIDTH-1:0]   wait_q, wait_d;
    logic                    wr_q;
    logic                    err_q;
    logic [IDX_W-1:0]        idx_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [BYTES-1:0]        strb_q;
    logic [DATA_WIDTH-1:0]   mem [0:DEPTH-1];

    logic                    cap;
    logic                    pready_d, pslverr_d;
    logic [DATA_WIDTH-1:0]   prdata_d;
    logic                    mem_we, err_inc;
    logic                    rsp_set, rsp_err, rsp_wr;
    logic [IDX_W-1:0]        rsp_idx;

    // Error decode on the live setup-phase address
    logic [ADDRESS_WIDTH-1:0] offset;
    logic                     below, above, misaligned, setup_err;
    logic [IDX_W-1:0]         setup_idx;

    assign offset    = paddr - BASE_ADDR;
    assign setup_idx = offset[LSB +: IDX_W];
    assign above     = {1'b0, paddr} >= END_ADDR;

    generate
        if (BASE_ADDR == '0) begin : g_no_below
            assign below = 1'b0;
        end else begin : g_below
            assign below = paddr < BASE_ADDR;
        end
        if (LSB == 0) begin : g_byte_wide
            assign misaligned = 1'b0;
        end else begin : g_align
            assign misaligned = paddr[LSB-1:0] != '0;
        end
    endgenerate

    assign setup_err = below | above | misaligned | (cfg_secure_only & pprot[1]);

    logic unused_bits;
    assign unused_bits = ^{pprot[2], pprot[0], offset};

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        cap       = 1'b0;
        pready_d  = pready;
        pslverr_d = pslverr;
        prdata_d  = prdata;
        mem_we    = 1'b0;
        err_inc   = 1'b0;
        rsp_set   = 1'b0;
        rsp_err   = err_q;
        rsp_wr    = wr_q;
        rsp_idx   = idx_q;

        case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    cap     = 1'b1;
                    wait_d  = cfg_wait_states;
                    state_d = ACCESS;
                    if (cfg_wait_states == '0) begin
                        rsp_set = 1'b1;
                        rsp_err = setup_err;
                        rsp_wr  = pwrite;
                        rsp_idx = setup_idx;
                    end
                end
            end
            ACCESS: begin
                if (!psel) begin
                    state_d   = IDLE;
                    wait_d    = '0;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    prdata_d  = '0;
                end else if (pready) begin
                    if (penable) begin
                        mem_we    = wr_q & ~err_q;
                        err_inc   = err_q;
                        state_d   = IDLE;
                        pready_d  = 1'b0;
                        pslverr_d = 1'b0;
                        prdata_d  = '0;
                    end
                end else begin
                    wait_d = wait_q - WAIT_WIDTH'(1);
                    if (wait_q == WAIT_WIDTH'(1)) begin
                        rsp_set = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Response is registered on the same edge pready rises
        if (rsp_set) begin
            pready_d  = 1'b1;
            pslverr_d = rsp_err;
            prdata_d  = (rsp_err || rsp_wr) ? '0 : mem[rsp_idx];
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q   <= IDLE;
            wait_q    <= '0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            pready    <= 1'b0;
            pslverr   <= 1'b0;
            prdata    <= '0;
            err_count <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            pready  <= pready_d;
            pslverr <= pslverr_d;
            prdata  <= prdata_d;
            if (cap) begin
                wr_q    <= pwrite;
                err_q   <= setup_err;
                idx_q   <= setup_idx;
                wdata_q <= pwdata;
                strb_q  <= pstrb;
            end
            if (err_inc && err_count != 16'hFFFF) begin
                err_count <= err_count + 16'd1;
            end
        end
    end

    // Memory is deliberately outside the reset domain so contents survive reset
    always_ff @(posedge pclk) begin
        for (int i = 0; i < BYTES; i++) begin
            if (mem_we && strb_q[i]) begin
                mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

endmodule

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
- Synthesisable APB4 completer with a word-addressed memory, parametrised in address/data width, memory size and base address.
- Adds per-transfer programmable wait states, byte-strobe writes, and PSLVERR generation for out-of-range, misaligned and protection-violating accesses.
- Sits behind one PSEL line of the APB interconnect. Used as the DUT-side slave model for master-agent regressions.

Parameters:
- ADDRESS_WIDTH, 32, paddr width.
- DATA_WIDTH, 32, data width; must be 8, 16, 32 or 64.
- MEM_SIZE_KB, 12, memory size in KB. Word depth = MEM_SIZE_KB*1024/(DATA_WIDTH/8).
- BASE_ADDR, 0, byte address of the first memory word.
- WAIT_WIDTH, 4, width of cfg_wait_states; maximum wait = 2^WAIT_WIDTH-1.

Ports:
- pclk  in  1  APB clock; all logic on rising edge.
- preset_n  in  1  asynchronous active-low reset.
- psel  in  1  slave select.
- penable  in  1  access phase.
- pwrite  in  1  1=write, 0=read.
- paddr  in  ADDRESS_WIDTH  byte address.
- pwdata  in  DATA_WIDTH  write data.
- pstrb  in  DATA_WIDTH/8  write byte strobes.
- pprot  in  3  protection; pprot[1]=1 means non-secure.
- pready  out  1  transfer complete.
- prdata  out  DATA_WIDTH  read data.
- pslverr  out  1  error response.
- cfg_wait_states  in  WAIT_WIDTH  wait states for the next transfer.
- cfg_secure_only  in  1  reject non-secure accesses.
- err_count  out  16  saturating count of error responses.

Behaviour:
- Reset (async, preset_n=0): pready=0, prdata=0, pslverr=0, err_count=0, state=IDLE, wait counter=0. Memory contents are NOT cleared.
- States: IDLE, ACCESS.
- IDLE:
  - On a rising edge with psel=1 and penable=0 (setup phase), capture pwrite, paddr, pwdata, pstrb, pprot and cfg_wait_states.
  - Compute err = (paddr < BASE_ADDR) | (paddr >= BASE_ADDR + MEM_SIZE_KB*1024) | (paddr[log2(DATA_WIDTH/8)-1:0] != 0) | (cfg_secure_only & pprot[1]).
  - Load the wait counter, then go to ACCESS.
- Wait states:
  - If the loaded wait count is 0, pready is registered high at the same edge, so pready=1 in the first access cycle.
  - Otherwise the counter decrements each access cycle. pready is driven high at the edge where the counter reaches 0.
  - Result: exactly N access cycles with pready=0, then one cycle with pready=1.
- prdata and pslverr are registered on the same edge pready rises:
  - err=1: pslverr=1, prdata=0.
  - Read without error: prdata=mem[word index], pslverr=0.
  - Write: prdata=0.
- Completion edge (psel=1, penable=1, pready=1):
  - Write without error: memory byte lane i is updated iff pstrb[i]=1. pstrb=0 writes nothing and is not an error.
  - Read: pstrb is ignored.
  - If err=1: memory is untouched and err_count increments, saturating at 16'hFFFF.
  - Then pready, pslverr and prdata return to 0 and state goes to IDLE.
- Back-to-back transfers: psel held high with penable=0 in the cycle after completion is a new setup phase, and is handled by IDLE at the next edge.
- Signals changing during ACCESS: address, control and cfg inputs are ignored.
- Abort: psel=0 during ACCESS before completion returns to IDLE, clears pready and pslverr, performs no write and does not increment err_count.
- pslverr is never 1 while pready=0.
- Simultaneous events: the cfg_wait_states change that coincides with a setup edge is the value captured.
- Reset mid-transfer: outputs clear immediately and the transfer is discarded; memory retains prior writes.

Test Plan:
1. Write 32'hDEADBEEF to 0x10 (pstrb 4'hF, wait 0), then read 0x10 -> pready=1 in first access cycle of each transfer; read prdata=32'hDEADBEEF, pslverr=0.
2. Write 32'h11223344 to 0x10 with pstrb 4'b0101, then read -> prdata=32'hDE22BE44.
3. cfg_wait_states=3, read 0x10 -> exactly 3 access cycles with pready=0; pready=1 with correct data on the 4th.
4. Address and alignment checks:
   - Read 0x2FFC -> pslverr=0.
   - Read 0x3000 -> pslverr=1, prdata=0, err_count=1.
   - Write to 0x12 -> pslverr=1, err_count=2, memory unchanged.
5. cfg_secure_only=1, write 32'hA5A5A5A5 to 0x20 with pprot=3'b010 -> pslverr=1. Read with pprot=3'b000 returns the previous contents.
6. Reset and abort:
   - Assert preset_n=0 during wait state 2 of a write to 0x10 -> pready, pslverr, prdata and err_count are 0 immediately.
   - After release, read 0x10 returns 32'hDE22BE44.
   - psel dropped mid-wait -> no write, next transfer completes normally.
